mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly downstream of EX.
- Consumes the EX/MEM-registered ALU result (address or arithmetic result), the forwarded rt store data and the destination register.
- Drives a req/ack data-memory port and performs byte/halfword alignment and load extension.
- Stalls upstream while an access is outstanding and registers the MEM/WB outputs.

---
 rtl/mem_pkg.sv | 51 +++++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage_load_align.sv | 34 +++
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the MEM pipeline stage (memory op codes,
// FSM states, byte-enable patterns) and small memop decode helpers.
package mem_pkg;

  localparam logic [3:0] MEMOP_NONE = 4'd0;
  localparam logic [3:0] MEMOP_LB   = 4'd1;
  localparam logic [3:0] MEMOP_LBU  = 4'd2;
  localparam logic [3:0] MEMOP_LH   = 4'd3;
  localparam logic [3:0] MEMOP_LHU  = 4'd4;
  localparam logic [3:0] MEMOP_LW   = 4'd5;
  localparam logic [3:0] MEMOP_SB   = 4'd6;
  localparam logic [3:0] MEMOP_SH   = 4'd7;
  localparam logic [3:0] MEMOP_SW   = 4'd8;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Access width of a memop; codes 9-15 behave as NONE.
  function automatic size_t memop_size(input logic [3:0] op);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: memop_size = SZ_BYTE;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: memop_size = SZ_HALF;
      MEMOP_LW, MEMOP_SW:            memop_size = SZ_WORD;
      default:                       memop_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic memop_is_load(input logic [3:0] op);
    memop_is_load = (op >= MEMOP_LB) && (op <= MEMOP_LW);
  endfunction

  function automatic logic memop_is_store(input logic [3:0] op);
    memop_is_store = (op >= MEMOP_SB) && (op <= MEMOP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data-memory port between the MEM stage (master)
// and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte/halfword out of a read word and
// sign- or zero-extends it according to the memop. Purely combinational,
// shared with the MEM-forward path.
module load_align
  import mem_pkg::*;
(
  input  logic [3:0]  memop,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // Lane selection and extension.
  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    sext     = (memop == MEMOP_LB) || (memop == MEMOP_LH);
    case (memop_size(memop))
      SZ_BYTE: load_value = sext ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      SZ_HALF: load_value = sext ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline. Drives the req/ack
// data-memory port, aligns stores and extends loads, stalls upstream while
// an access is outstanding and registers the MEM/WB outputs.
// Optional build macro MEM_TIMEOUT_EN: abort a WAIT after TIMEOUT_CYC cycles
// without ack and pulse bus_err.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_storedata,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_value,
  output logic        addr_err,
  output logic        bus_err
);

  state_t      state_q, state_d;
  size_t       size;
  logic        is_load, is_store, is_mem, misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_value;
  logic        req, abort;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_value_q, wb_value_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;

  // Decode, alignment check and store lane replication.
  always_comb begin
    size     = memop_size(ex_memop);
    is_load  = memop_is_load(ex_memop);
    is_store = memop_is_store(ex_memop);
    is_mem   = is_load | is_store;
    case (size)
      SZ_BYTE: begin
        misaligned = 1'b0;
        lane_be    = BE_BYTE0 << ex_aluout[1:0];
        lane_wdata = {4{ex_storedata[7:0]}};
      end
      SZ_HALF: begin
        misaligned = ex_aluout[0];
        lane_be    = ex_aluout[1] ? BE_HALF_HI : BE_HALF_LO;
        lane_wdata = {2{ex_storedata[15:0]}};
      end
      SZ_WORD: begin
        misaligned = |ex_aluout[1:0];
        lane_be    = BE_WORD;
        lane_wdata = ex_storedata;
      end
      default: begin
        misaligned = 1'b0;
        lane_be    = BE_NONE;
        lane_wdata = ex_storedata;
      end
    endcase
  end

  load_align u_load_align (
    .memop      (ex_memop),
    .addr       (ex_aluout[1:0]),
    .rdata      (dmem.dmem_rdata),
    .load_value (load_value)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Cycles spent in WAIT; held at zero in IDLE so it starts fresh on entry.
  always_comb begin
    tmo_cnt_d = (state_q == ST_WAIT) ? tmo_cnt_q + CNT_W'(1) : '0;
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // FSM next state, request and stall generation.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req = ex_valid & is_mem & ~misaligned;
        if (req && !dmem.dmem_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ack) begin
          state_d = ST_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    mem_stall        = req & ~dmem.dmem_ack & ~abort;
    dmem.dmem_req    = req;
    dmem.dmem_we     = req & is_store;
    dmem.dmem_be     = req ? lane_be : BE_NONE;
    dmem.dmem_addr   = {ex_aluout[31:2], 2'b00};
    dmem.dmem_wdata  = lane_wdata;
  end

  // MEM/WB next values; a stall inserts a bubble and holds payload.
  always_comb begin
    wb_valid_d    = ex_valid;
    wb_regwrite_d = ex_regwrite & ~misaligned & ~is_store & ~abort;
    wb_rd_d       = ex_rd;
    wb_value_d    = is_load ? load_value : ex_aluout;
    addr_err_d    = ex_valid & misaligned;
    bus_err_d     = abort;
    if (mem_stall) begin
      wb_valid_d    = 1'b0;
      wb_regwrite_d = 1'b0;
      wb_rd_d       = wb_rd_q;
      wb_value_d    = wb_value_q;
      addr_err_d    = 1'b0;
    end
  end

  // State and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_value_q    <= '0;
      addr_err_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_value_q    <= wb_value_d;
      addr_err_q    <= addr_err_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_value    = wb_value_q;
  assign addr_err    = addr_err_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of the MEM stage against a
// byte-lane reference model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_memop;
  logic [31:0] ex_aluout;
  logic [31:0] ex_storedata;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        mem_stall;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic        addr_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_stage_if dif ();

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_memop     (ex_memop),
    .ex_aluout    (ex_aluout),
    .ex_storedata (ex_storedata),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .dmem         (dif),
    .mem_stall    (mem_stall),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_value     (wb_value),
    .addr_err     (addr_err),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int ref_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic int ref_offset(input logic [3:0] op, input logic [31:0] a);
    int n = ref_bytes(op);
    if (n == 1) return int'(a % 4);
    if (n == 2) return int'(a % 4) / 2 * 2;
    return 0;
  endfunction

  function automatic logic ref_misaligned(input logic [3:0] op, input logic [31:0] a);
    int n = ref_bytes(op);
    return (n > 1) && ((a % n) != 0);
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] a);
    int n = ref_bytes(op);
    return 4'(((1 << n) - 1) << ref_offset(op, a));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] sd);
    logic [31:0] w;
    int n = ref_bytes(op);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    int n = ref_bytes(op);
    logic [31:0] v, mask;
    if (n == 4) return rd;
    v    = rd >> (8 * ref_offset(op, a));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [3:0] op, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd, input logic rw);
    ex_valid     = v;
    ex_memop     = op;
    ex_aluout    = alu;
    ex_storedata = sd;
    ex_rd        = rd;
    ex_regwrite  = rw;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_ex(0, 4'd0, '0, '0, '0, 0);
    dif.dmem_ack = 1'b0;
    dif.dmem_rdata = '0;
    step();
    step();
    #3;
    checks++;
    if ({wb_valid, wb_regwrite, wb_rd, wb_value, addr_err, bus_err} !== '0) begin
      errors++;
      $display("FAIL reset_regs got v=%0b rw=%0b rd=%0d val=%h ae=%0b be=%0b exp all 0",
               wb_valid, wb_regwrite, wb_rd, wb_value, addr_err, bus_err);
    end
    step();
    rst = 1'b0;
    #3;
    checks++;
    if ({dif.dmem_req, mem_stall} !== 2'b00) begin
      errors++;
      $display("FAIL reset_req got req=%0b stall=%0b exp 0 0", dif.dmem_req, mem_stall);
    end
  endtask

  task automatic test_lb_same_cycle();
    step();
    drive_ex(1, 4'd1, 32'h0000_1003, '0, 5'd9, 1);
    dif.dmem_ack = 1'b1;
    dif.dmem_rdata = 32'h80FF_1234;
    #3;
    checks++;
    if ({dif.dmem_req, mem_stall, dif.dmem_we, dif.dmem_be, dif.dmem_addr} !==
        {1'b1, 1'b0, 1'b0, 4'b1000, 32'h0000_1000}) begin
      errors++;
      $display("FAIL lb_bus got req=%0b stall=%0b we=%0b be=%b addr=%h exp 1 0 0 1000 00001000",
               dif.dmem_req, mem_stall, dif.dmem_we, dif.dmem_be, dif.dmem_addr);
    end
    step();
    drive_ex(0, 4'd0, '0, '0, '0, 0);
    dif.dmem_ack = 1'b0;
    #3;
    checks++;
    if ({wb_valid, wb_regwrite, wb_rd, wb_value} !== {1'b1, 1'b1, 5'd9, 32'hFFFF_FF80}) begin
      errors++;
      $display("FAIL lb_wb got v=%0b rw=%0b rd=%0d val=%h exp 1 1 9 ffffff80",
               wb_valid, wb_regwrite, wb_rd, wb_value);
    end
  endtask

  task automatic test_lhu_wait();
    int stalls = 0;
    int bubbles_bad = 0;
    int req_bad = 0;
    bit done = 0;
    step();
    drive_ex(1, 4'd4, 32'h0000_2002, '0, 5'd4, 1);
    dif.dmem_ack = 1'b0;
    dif.dmem_rdata = 32'h8001_0000;
    for (int c = 0; c < 10 && !done; c++) begin
      #3;
      if (dif.dmem_req !== 1'b1 || dif.dmem_addr !== 32'h0000_2000 || dif.dmem_be !== 4'b1100)
        req_bad++;
      if (c > 0 && wb_valid !== 1'b0) bubbles_bad++;
      if (mem_stall === 1'b1) stalls++;
      done = dif.dmem_ack;
      step();
      if (c == 2) dif.dmem_ack = 1'b1;
    end
    drive_ex(0, 4'd0, '0, '0, '0, 0);
    dif.dmem_ack = 1'b0;
    #3;
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("FAIL lhu_stall_cycles got %0d exp 3", stalls);
    end
    checks++;
    if (req_bad != 0 || bubbles_bad != 0) begin
      errors++;
      $display("FAIL lhu_req_stable got bad_req=%0d bad_bubble=%0d exp 0 0", req_bad, bubbles_bad);
    end
    checks++;
    if ({wb_valid, wb_regwrite, wb_value} !== {1'b1, 1'b1, 32'h0000_8001}) begin
      errors++;
      $display("FAIL lhu_wb got v=%0b rw=%0b val=%h exp 1 1 00008001",
               wb_valid, wb_regwrite, wb_value);
    end
  endtask

  task automatic test_sh_store();
    step();
    drive_ex(1, 4'd7, 32'h0000_0010, 32'h1234_ABCD, 5'd2, 1);
    dif.dmem_ack = 1'b1;
    #3;
    checks++;
    if ({dif.dmem_req, dif.dmem_we, dif.dmem_be, dif.dmem_wdata, mem_stall} !==
        {1'b1, 1'b1, 4'b0011, 32'hABCD_ABCD, 1'b0}) begin
      errors++;
      $display("FAIL sh_bus got req=%0b we=%0b be=%b wdata=%h stall=%0b exp 1 1 0011 abcdabcd 0",
               dif.dmem_req, dif.dmem_we, dif.dmem_be, dif.dmem_wdata, mem_stall);
    end
    step();
    drive_ex(0, 4'd0, '0, '0, '0, 0);
    dif.dmem_ack = 1'b0;
    #3;
    checks++;
    if ({wb_valid, wb_regwrite} !== 2'b10) begin
      errors++;
      $display("FAIL sh_wb got v=%0b rw=%0b exp 1 0", wb_valid, wb_regwrite);
    end
  endtask

  task automatic test_misaligned();
    step();
    drive_ex(1, 4'd5, 32'h0000_0102, '0, 5'd6, 1);
    dif.dmem_ack = 1'b0;
    #3;
    checks++;
    if ({dif.dmem_req, mem_stall} !== 2'b00) begin
      errors++;
      $display("FAIL mis_req got req=%0b stall=%0b exp 0 0", dif.dmem_req, mem_stall);
    end
    step();
    drive_ex(0, 4'd0, '0, '0, '0, 0);
    #3;
    checks++;
    if ({wb_valid, wb_regwrite, addr_err} !== 3'b101) begin
      errors++;
      $display("FAIL mis_wb got v=%0b rw=%0b addr_err=%0b exp 1 0 1", wb_valid, wb_regwrite, addr_err);
    end
    step();
    #3;
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse got addr_err=%0b exp 0", addr_err);
    end
  endtask

  task automatic test_passthrough_reset();
    step();
    drive_ex(1, 4'd0, 32'h0000_0055, '0, 5'd7, 1);
    dif.dmem_ack = 1'b0;
    step();
    drive_ex(1, 4'd8, 32'h0000_0040, 32'hDEAD_BEEF, 5'd3, 0);
    #3;
    checks++;
    if ({wb_valid, wb_regwrite, wb_rd, wb_value} !== {1'b1, 1'b1, 5'd7, 32'h0000_0055}) begin
      errors++;
      $display("FAIL add_wb got v=%0b rw=%0b rd=%0d val=%h exp 1 1 7 00000055",
               wb_valid, wb_regwrite, wb_rd, wb_value);
    end
    checks++;
    if (mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL sw_stall got %0b exp 1", mem_stall);
    end
    step();
    #3;
    checks++;
    if ({dif.dmem_req, mem_stall} !== 2'b11) begin
      errors++;
      $display("FAIL sw_wait got req=%0b stall=%0b exp 1 1", dif.dmem_req, mem_stall);
    end
    step();
    rst = 1'b1;
    drive_ex(0, 4'd0, '0, '0, '0, 0);
    step();
    rst = 1'b0;
    dif.dmem_ack = 1'b1;
    #3;
    checks++;
    if ({dif.dmem_req, mem_stall, wb_valid, wb_regwrite, wb_rd, wb_value} !== '0) begin
      errors++;
      $display("FAIL rst_wait got req=%0b stall=%0b v=%0b rw=%0b rd=%0d val=%h exp all 0",
               dif.dmem_req, mem_stall, wb_valid, wb_regwrite, wb_rd, wb_value);
    end
    step();
    dif.dmem_ack = 1'b0;
    #3;
    checks++;
    if ({wb_valid, wb_regwrite, addr_err, bus_err, dif.dmem_req} !== 5'b0) begin
      errors++;
      $display("FAIL late_ack got v=%0b rw=%0b ae=%0b be=%0b req=%0b exp all 0",
               wb_valid, wb_regwrite, addr_err, bus_err, dif.dmem_req);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int stalls = 0;
    bit done = 0;
    step();
    drive_ex(1, 4'd5, 32'h0000_0200, '0, 5'd8, 1);
    dif.dmem_ack = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      #3;
      if (mem_stall === 1'b1) stalls++;
      else done = 1;
      step();
    end
    drive_ex(0, 4'd0, '0, '0, '0, 0);
    #3;
    checks++;
    if (stalls != 4) begin
      errors++;
      $display("FAIL tmo_stall_cycles got %0d exp 4", stalls);
    end
    checks++;
    if ({wb_valid, wb_regwrite, bus_err} !== 3'b101) begin
      errors++;
      $display("FAIL tmo_wb got v=%0b rw=%0b bus_err=%0b exp 1 0 1", wb_valid, wb_regwrite, bus_err);
    end
    step();
    #3;
    checks++;
    if ({bus_err, dif.dmem_req} !== 2'b00) begin
      errors++;
      $display("FAIL tmo_pulse got bus_err=%0b req=%0b exp 0 0", bus_err, dif.dmem_req);
    end
  endtask
`endif

  task automatic test_random(input int n_ops);
    for (int t = 0; t < n_ops; t++) begin
      logic [3:0]  op;
      logic [31:0] a, sd, rdat;
      logic [4:0]  rd;
      logic        v, rw, mis, exp_req, st, ld, exp_rw;
      int          delay, stalls, bus_bad;
      bit          done;
      op    = 4'($urandom_range(0, 15));
      a     = $urandom;
      sd    = $urandom;
      rdat  = $urandom;
      rd    = 5'($urandom);
      v     = ($urandom_range(0, 7) != 0);
      rw    = 1'($urandom);
      delay = $urandom_range(0, 3);
      ld    = (op >= 4'd1 && op <= 4'd5);
      st    = (op >= 4'd6 && op <= 4'd8);
      mis   = ref_misaligned(op, a);
      exp_req = v && (ld || st) && !mis;
      exp_rw  = rw && !mis && !st;
      stalls  = 0;
      bus_bad = 0;
      done    = 0;
      step();
      drive_ex(v, op, a, sd, rd, rw);
      dif.dmem_rdata = rdat;
      dif.dmem_ack   = exp_req ? (delay == 0) : 1'($urandom);
      for (int c = 0; c < 8 && !done; c++) begin
        #3;
        checks++;
        if (dif.dmem_req !== exp_req) begin
          errors++;
          $display("FAIL rnd_req op=%0d a=%h got %0b exp %0b", op, a, dif.dmem_req, exp_req);
        end
        if (exp_req && {dif.dmem_we, dif.dmem_be, dif.dmem_addr} !==
            {st, ref_be(op, a), a & 32'hFFFF_FFFC}) bus_bad++;
        if (exp_req && st && dif.dmem_wdata !== ref_wdata(op, sd)) bus_bad++;
        if (mem_stall === 1'b1) stalls++;
        step();
        if (!exp_req || c == delay) done = 1;
        else if (c + 1 == delay) dif.dmem_ack = 1'b1;
      end
      drive_ex(0, 4'd0, '0, '0, '0, 0);
      dif.dmem_ack = 1'b0;
      #3;
      checks++;
      if (bus_bad != 0 || stalls != (exp_req ? delay : 0)) begin
        errors++;
        $display("FAIL rnd_bus op=%0d a=%h bad=%0d stalls=%0d exp 0 %0d",
                 op, a, bus_bad, stalls, exp_req ? delay : 0);
      end
      checks++;
      if ({wb_valid, wb_regwrite, addr_err} !== {v, exp_rw, v & mis}) begin
        errors++;
        $display("FAIL rnd_wbctl op=%0d a=%h got v=%0b rw=%0b ae=%0b exp %0b %0b %0b",
                 op, a, wb_valid, wb_regwrite, addr_err, v, exp_rw, v & mis);
      end
      if (v && exp_rw) begin
        checks++;
        if ({wb_rd, wb_value} !== {rd, ld ? ref_load(op, a, rdat) : a}) begin
          errors++;
          $display("FAIL rnd_wbval op=%0d a=%h rdata=%h got rd=%0d val=%h exp %0d %h",
                   op, a, rdat, wb_rd, wb_value, rd, ld ? ref_load(op, a, rdat) : a);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_ex(0, 4'd0, '0, '0, '0, 0);
    dif.dmem_ack = 1'b0;
    dif.dmem_rdata = '0;
    test_reset();
    test_lb_same_cycle();
    test_lhu_wait();
    test_sh_store();
    test_misaligned();
    test_passthrough_reset();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_random(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
